// File: rtl/b13_pkg.sv
// Shared b13 link definitions: line levels, timing constants, transmitter and receiver state encodings.
package b13_pkg;

  localparam int unsigned B13_DELAY      = 104;
  localparam int unsigned B13_BIT_PERIOD = B13_DELAY + 2;
  localparam int unsigned B13_CNT_W      = 10;
  localparam int unsigned B13_DATA_W     = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_START = 2'd1,
    G_DATA  = 2'd2,
    G_STOP  = 2'd3
  } b13_tx_state_e;

  typedef enum logic [2:0] {
    R_IDLE      = 3'd0,
    R_START     = 3'd1,
    R_DATA      = 3'd2,
    R_STOP      = 3'd3,
    R_WAIT_HIGH = 3'd4
  } b13_rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to a chosen level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_rx_b13.sv
// b13 serial receiver: mid-bit sampling deserializer with a valid/ack hold register and sticky error flags.
module serial_rx_b13
  import b13_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = B13_BIT_PERIOD
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_line,
  input  logic       rx_en,
  output logic [7:0] dato,
  output logic       dato_valid,
  input  logic       rd_ack,
  output logic       frame_error,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [B13_CNT_W-1:0] HALF_M1 = B13_CNT_W'(HALF_PERIOD - 1);
  localparam logic [B13_CNT_W-1:0] BIT_M1  = B13_CNT_W'(BIT_PERIOD - 1);

  logic                  rx_s;
  b13_rx_state_e         state_q;
  logic [B13_CNT_W-1:0]  cnt_q;
  logic [2:0]            bit_idx_q;
  logic [7:0]            shreg_q;
  logic [7:0]            dato_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic                  ovr_q;
  logic                  busy_q;

  sync2 #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk   (clock),
    .rst_n (reset_n),
    .d_i   (rx_line),
    .q_o   (rx_s)
  );

  // Clears are applied first so that a same-cycle set or reload takes precedence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      dato_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (rd_ack && valid_q) valid_q <= 1'b0;
      if (err_clr) begin
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (!rx_en && state_q != R_IDLE) begin
        state_q <= R_IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          R_IDLE: begin
            if (rx_en && rx_s == START_BIT) begin
              state_q <= R_START;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          R_START: begin
            if (cnt_q == HALF_M1) begin
              cnt_q <= '0;
              if (rx_s == START_BIT) begin
                state_q   <= R_DATA;
                bit_idx_q <= '0;
              end else begin
                state_q <= R_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          R_DATA: begin
            if (cnt_q == BIT_M1) begin
              cnt_q     <= '0;
              shreg_q   <= {shreg_q[6:0], rx_s};
              bit_idx_q <= bit_idx_q + 1'b1;
              if (bit_idx_q == 3'd7) state_q <= R_STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          R_STOP: begin
            if (cnt_q == BIT_M1) begin
              cnt_q <= '0;
              if (rx_s == STOP_BIT) begin
                if (!valid_q || rd_ack) begin
                  dato_q  <= shreg_q;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
                state_q <= R_IDLE;
                busy_q  <= 1'b0;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= R_WAIT_HIGH;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          R_WAIT_HIGH: begin
            if (rx_s == LINE_IDLE) begin
              state_q <= R_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dato        = dato_q;
  assign dato_valid  = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_rx_b13.sv
// Self-checking bench for serial_rx_b13: directed vector table, corner sequences and a randomized model run.
module tb_serial_rx_b13;

  localparam int BP = 106;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       rx_en = 1'b1;
  logic       rd_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dato;
  logic       dato_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int passed = 0;

  serial_rx_b13 dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_line     (rx_line),
    .rx_en       (rx_en),
    .dato        (dato),
    .dato_valid  (dato_valid),
    .rd_ack      (rd_ack),
    .frame_error (frame_error),
    .overrun     (overrun),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ack_before;
    logic       clr_before;
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dato;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    clks(1);
    rd_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    rx_line = 1'b0;
    clks(BP);
    for (int i = 7; i >= 0; i--) begin
      rx_line = b[i];
      clks(BP);
    end
  endtask

  // Stop bit held for stop_len clocks, then the line returns to idle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    send_data(b);
    rx_line = stop;
    clks(stop_len);
    rx_line = 1'b1;
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] d, input logic v,
                          input logic fe, input logic ov, input logic bz);
    chk({tag, ".dato"}, dato, d);
    chk({tag, ".valid"}, 8'(dato_valid), 8'(v));
    chk({tag, ".frame_error"}, 8'(frame_error), 8'(fe));
    chk({tag, ".overrun"}, 8'(overrun), 8'(ov));
    chk({tag, ".busy"}, 8'(busy), 8'(bz));
  endtask

  logic [7:0] m_dato;
  logic       m_valid, m_fe, m_ov;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h22, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h44, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h44, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0};

    #2;
    chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    clks(3);
    reset_n = 1'b1;
    clks(5);
    chk_outs("post_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exact load edge of frame 0xA5.
    fork
      send_frame(8'hA5, 1'b1, BP);
      begin
        clks(1009);
        chk("a5_pre.valid", 8'(dato_valid), 8'h0);
        chk("a5_pre.busy", 8'(busy), 8'h1);
        clks(1);
        chk("a5_load.valid", 8'(dato_valid), 8'h1);
        chk("a5_load.dato", dato, 8'hA5);
        chk("a5_load.busy", 8'(busy), 8'h0);
      end
    join
    clks(10);
    chk_outs("a5_done", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    // Short glitch: false start.
    rx_line = 1'b0;
    clks(20);
    rx_line = 1'b1;
    chk("glitch.busy_high", 8'(busy), 8'h1);
    clks(60);
    chk_outs("glitch_done", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    // rx_en dropped mid-frame.
    fork
      send_frame(8'h00, 1'b1, BP);
      begin
        clks(300);
        chk("abort.busy_before", 8'(busy), 8'h1);
        rx_en = 1'b0;
        clks(1);
        chk("abort.busy_after", 8'(busy), 8'h0);
      end
    join
    clks(5);
    rx_en = 1'b1;
    clks(5);
    chk_outs("abort_done", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ack_before) pulse_ack();
      if (vecs[i].clr_before) pulse_clr();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop ? BP : 300);
      clks(20);
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_dato, vecs[i].exp_valid,
               vecs[i].exp_fe, vecs[i].exp_ov, 1'b0);
    end

    // Break after a bad stop: busy holds until the line returns high.
    pulse_ack();
    send_data(8'h3C);
    rx_line = 1'b0;
    clks(300);
    chk("break.busy", 8'(busy), 8'h1);
    chk("break.frame_error", 8'(frame_error), 8'h1);
    chk("break.valid", 8'(dato_valid), 8'h0);
    rx_line = 1'b1;
    clks(10);
    chk("break.busy_release", 8'(busy), 8'h0);
    pulse_clr();
    chk("break.err_clr", 8'(frame_error), 8'h0);

    // rd_ack coincident with the stop sample of the second frame.
    send_frame(8'h11, 1'b1, BP);
    clks(5);
    chk("coinc.first", dato, 8'h11);
    fork
      send_frame(8'h22, 1'b1, BP);
      begin
        clks(1009);
        rd_ack = 1'b1;
        clks(1);
        rd_ack = 1'b0;
      end
    join
    clks(5);
    chk_outs("coinc", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of frame 0xFF.
    fork
      send_frame(8'hFF, 1'b1, BP);
      begin
        clks(500);
        #2 reset_n = 1'b0;
        #1 chk_outs("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clks(2);
        reset_n = 1'b1;
      end
    join
    clks(10);
    send_frame(8'h81, 1'b1, BP);
    clks(10);
    chk_outs("after_reset", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized frames against a behavioural model of the hold register and flags.
    m_dato = 8'h81; m_valid = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    for (int n = 0; n < 12; n++) begin
      logic [31:0] r;
      logic [7:0]  b;
      logic        bad;
      r   = $urandom;
      b   = 8'($urandom_range(0, 255));
      bad = (r[5:3] == 3'd0);
      if (r[0]) begin
        pulse_ack();
        m_valid = 1'b0;
      end
      if (r[1] && r[2]) begin
        pulse_clr();
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
      send_frame(b, !bad, bad ? 150 + int'(r[12:6]) : BP);
      clks(10);
      if (bad) m_fe = 1'b1;
      else if (m_valid) m_ov = 1'b1;
      else begin
        m_dato  = b;
        m_valid = 1'b1;
      end
      chk_outs($sformatf("rand%0d", n), m_dato, m_valid, m_fe, m_ov, 1'b0);
      clks(int'(r[15:13]) + 2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_rx_b13.md
Name: serial_rx_b13

Overview:
- Receive end of the b13 asynchronous serial link. Deserializes the transmitter's line format: idle high, start bit 0, 8 data bits MSB first, stop bit 1, 106 clocks per bit.
- Presents each received byte to a downstream consumer through a valid/acknowledge hold register.
- Reports framing errors and overruns with sticky flags.
- Sits opposite the b13 transmitter, on the same clock domain or a plesiochronous one.

Parameters:
- BIT_PERIOD, 106, clocks per serial bit (transmitter delay 104 + 2). Legal range 4..1023.
- HALF_PERIOD, BIT_PERIOD/2 (53), clocks from detected start edge to start-bit mid-sample.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- rx_line  in  1  serial input, idle high, asynchronous to clock
- rx_en  in  1  receiver enable; when 0, idle and ignore the line
- dato  out  8  last accepted byte
- dato_valid  out  1  dato holds an unread byte
- rd_ack  in  1  consumer has taken dato; honoured only while dato_valid=1
- frame_error  out  1  sticky: stop bit sampled 0
- overrun  out  1  sticky: frame completed while dato_valid=1
- err_clr  in  1  clears frame_error and overrun
- busy  out  1  frame in progress (state not R_IDLE)

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; dato=8'h00.
  - State is R_IDLE, bit counter 0, shift register 0.
  - Both synchronizer flops are 1.
- Input path: 2-flop synchronizer gives rx_s. Every timing figure below is relative to rx_s.
- Counter: 10-bit cnt. It resets to 0 on every state entry and after every sample, and never wraps past BIT_PERIOD-1.
- States (2-bit): R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: if rx_en=1 and rx_s=0, go to R_START. Call this edge "cycle 0".
  - R_START: at cnt==HALF_PERIOD-1 (cycle 53), sample rx_s.
    - rx_s=0: go to R_DATA, bit index=0.
    - rx_s=1: false start. Return to R_IDLE with no flags.
  - R_DATA: sample at cnt==BIT_PERIOD-1, i.e. cycles 53+106k for k=1..8.
    - Shift: shreg <= {shreg[6:0], rx_s}, so the first bit received lands in dato[7].
    - After the 8th sample, go to R_STOP.
  - R_STOP: sample at cycle 1007.
    - rx_s=1: frame good.
      - dato_valid=0: load dato<=shreg and set dato_valid. Both are visible after edge 1008.
      - dato_valid=1: set overrun, leave dato unchanged, discard the byte.
      - Go to R_IDLE.
    - rx_s=0: set frame_error, discard the byte, go to R_WAIT_HIGH.
  - R_WAIT_HIGH: stay until rx_s=1, then go to R_IDLE. This prevents re-triggering on a break. With this added state the encoding is 3 bits.
- rx_en deasserted mid-frame: abort to R_IDLE on the next edge. No flags are set and dato is untouched.
- Handshake:
  - rd_ack=1 while dato_valid=1 clears dato_valid on the next edge.
  - rd_ack while dato_valid=0 is ignored.
  - Simultaneous good stop-sample and rd_ack: the new byte is loaded, dato_valid stays 1, no overrun.
- err_clr:
  - Clears both sticky flags on the next edge.
  - If a flag-setting event occurs in the same cycle, set wins.
- busy=1 in every state except R_IDLE.
- Reset mid-frame: immediate return to reset values; the partial byte is lost.

Decomposition:
- Shared package b13_pkg holds:
  - state encodings R_IDLE..R_WAIT_HIGH, shared alongside the transmitter's G_* and bit encodings;
  - constant B13_DELAY=104;
  - BIT_PERIOD default derived as B13_DELAY+2.
- One sub-module: sync2, a 2-flop synchronizer with async active-low reset to a parameterized value (1 here). It is reusable for dsr/eoc elsewhere.

Test Plan:
1. Line idle, rx_en=1; drive frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,1 at 106 clocks each) -> dato=8'hA5 and dato_valid=1 at rx_s-cycle 1008, busy falls at the same edge, no flags.
2. Glitch: rx_line low for 20 clocks, then high -> R_START aborts at cycle 53, busy pulses then returns to 0, dato_valid=0, no flags.
3. Frame 0x3C with stop bit forced 0, line held low 300 clocks then high -> frame_error=1, dato_valid=0, busy stays 1 until the line returns high. err_clr then clears the flag.
4. Two back-to-back frames 0x11, 0x22 with no rd_ack -> dato=8'h11, overrun=1. rd_ack then a third frame 0x33 -> dato=8'h33, overrun still 1 until err_clr.
5. rd_ack asserted on the exact cycle of the second frame's stop sample -> dato=8'h22, dato_valid=1, overrun=0.
6. reset_n pulsed low at cycle 500 of frame 0xFF -> all outputs 0 immediately. The next clean frame 0x81 is received correctly.
